demux_scan_sequencer: RTL and testbench
=======================================

DEMUX_SCAN_SEQUENCER -- requirements
Module: demux_scan_sequencer

Interface
REQ-001 The block SHALL have parameter STEP_CYCLES, default 1, giving the number of clock cycles each select value is held (legal range 1..16).
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port load_data, input, 16 bits: the word to be scanned; bit n is routed to demux output n.
REQ-005 The block SHALL have port load_valid, input, 1 bit: load_data is valid.
REQ-006 The block SHALL have port load_ready, output, 1 bit: the sequencer accepts a word.
REQ-007 The block SHALL have port hold, input, 1 bit: freezes the scan in place.
REQ-008 The block SHALL have port demux_in, output, 1 bit: drives the demultiplexer data input.
REQ-009 The block SHALL have port demux_enable, output, 1 bit: drives the demultiplexer enable.
REQ-010 The block SHALL have port demux_sel, output, 4 bits: drives the demultiplexer select.
REQ-011 The block SHALL have port busy, output, 1 bit: high in SCAN and DONE.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse at scan completion.

Function
REQ-013 The block SHALL implement the FSM states IDLE, SCAN and DONE, with all outputs registered or decoded from registered state only.
REQ-014 In IDLE the block SHALL drive load_ready=1, demux_enable=0, demux_sel=0, demux_in=0 and busy=0.
REQ-015 A handshake (load_valid & load_ready at an edge) SHALL capture load_data into a shadow register and move the FSM to SCAN, with index=0 and dwell=0.
REQ-016 In SCAN the block SHALL drive demux_enable=1, demux_sel=index and demux_in=shadow[index], starting in the first cycle after the handshake.
REQ-017 In SCAN, while hold=0, dwell SHALL increment each cycle; when dwell==STEP_CYCLES-1, dwell SHALL clear and index SHALL increment.
REQ-018 While hold=1, index, dwell and all outputs SHALL remain frozen, and the scan length SHALL extend by exactly the number of hold cycles.
REQ-019 When index==15 and dwell==STEP_CYCLES-1 with hold=0, the FSM SHALL move to DONE; index SHALL NOT wrap to 0 within a scan.
REQ-020 DONE SHALL last exactly one cycle with done=1, demux_enable=0, demux_sel=0, demux_in=0 and load_ready=0, then return to IDLE.
REQ-021 load_ready SHALL be 0 in SCAN and DONE, and load_valid SHALL be ignored there; the next word is accepted no earlier than the first IDLE cycle.
REQ-022 Without hold, a scan SHALL occupy exactly 16*STEP_CYCLES SCAN cycles plus 1 DONE cycle.
REQ-023 hold SHALL have no effect in IDLE or DONE.

Reset
REQ-024 Asserting reset SHALL immediately force IDLE, index=0, dwell=0, shadow=0, load_ready=1, and demux_enable, demux_sel, demux_in, busy and done all to 0, regardless of clock.
REQ-025 A reset during SCAN SHALL abort the scan without asserting done.
REQ-026 No handshake SHALL occur while reset is high.

Configuration
REQ-027 Macro DEMUX_SEQ_SKIP_ZERO_EN SHALL control zero-bit skipping.
REQ-028 When DEMUX_SEQ_SKIP_ZERO_EN is defined, SCAN SHALL start at the lowest set bit of the shadow word and advance index to the next higher set bit, going to DONE after the highest set bit has been dwelt.
REQ-029 When DEMUX_SEQ_SKIP_ZERO_EN is defined, a zero word SHALL go IDLE->DONE directly, so demux_enable is never asserted.
REQ-030 When DEMUX_SEQ_SKIP_ZERO_EN is defined, scan length SHALL be popcount*STEP_CYCLES cycles.
REQ-031 When DEMUX_SEQ_SKIP_ZERO_EN is undefined, all 16 indices SHALL be visited as in REQ-017.

Verification
REQ-032 The bench SHALL cover: STEP_CYCLES=1, load 16'hA5C3 -> demux_sel steps 0..15 on consecutive cycles, demux_in follows the bits LSB-first, done pulses at cycle 17 after the handshake.
REQ-033 The bench SHALL cover: STEP_CYCLES=3, load 16'h0001 -> each sel held 3 cycles, demux_in=1 only during sel=0, 48 SCAN cycles, then done.
REQ-034 The bench SHALL cover: hold=1 for 5 cycles at sel=7 -> sel stays 7 and outputs stay frozen, done is delayed by exactly 5 cycles.
REQ-035 The bench SHALL cover: reset asserted at sel=9 -> outputs 0 asynchronously, no done, load_ready=1; a new load after reset scans from sel=0.
REQ-036 The bench SHALL cover: load_valid held high continuously -> back-to-back scans separated by exactly one DONE and one IDLE cycle, and the second word is captured only in IDLE.
REQ-037 The bench SHALL cover, with DEMUX_SEQ_SKIP_ZERO_EN defined: load 16'h8010 -> sel 4 then 15 only; load 16'h0000 -> done one cycle after the handshake, and demux_enable never asserts.

Source files
------------

// File: rtl/demux_scan_sequencer.sv
// ============================================================================
// Module      : demux_scan_sequencer
// Description : Serialises a 16-bit word onto a demultiplexer, holding each
//               select value for STEP_CYCLES clocks. Optional macro
//               DEMUX_SEQ_SKIP_ZERO_EN visits only the set bits of the word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_scan_sequencer #(
  parameter int STEP_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] load_data,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic        hold,
  output logic        demux_in,
  output logic        demux_enable,
  output logic [3:0]  demux_sel,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] C_IDLE       = 2'd0;
  localparam logic [1:0] C_SCAN       = 2'd1;
  localparam logic [1:0] C_DONE       = 2'd2;
  localparam logic [3:0] C_LAST_DWELL = 4'(STEP_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  index_q, index_d;
  logic [3:0]  dwell_q, dwell_d;
  logic [15:0] shadow_q, shadow_d;

`ifdef DEMUX_SEQ_SKIP_ZERO_EN
  // Returns {found, index} of the lowest set bit at or above 'from'.
  function automatic logic [4:0] first_set_from(input logic [15:0] word,
                                                input logic [4:0]  from);
    logic [4:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (word[i] && (5'(i) >= from)) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

  logic [4:0] w_first;
  logic [4:0] w_next;
  assign w_first = first_set_from(load_data, 5'd0);
  assign w_next  = first_set_from(shadow_q, {1'b0, index_q} + 5'd1);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= C_IDLE;
      index_q  <= '0;
      dwell_q  <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      dwell_q  <= dwell_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    dwell_d  = dwell_q;
    shadow_d = shadow_q;
    case (state_q)
      C_IDLE: begin
        if (load_valid) begin
          shadow_d = load_data;
          dwell_d  = '0;
`ifdef DEMUX_SEQ_SKIP_ZERO_EN
          if (w_first[4]) begin
            state_d = C_SCAN;
            index_d = w_first[3:0];
          end else begin
            state_d = C_DONE;
            index_d = '0;
          end
`else
          state_d = C_SCAN;
          index_d = '0;
`endif
        end
      end
      C_SCAN: begin
        if (!hold) begin
          if (dwell_q == C_LAST_DWELL) begin
            dwell_d = '0;
`ifdef DEMUX_SEQ_SKIP_ZERO_EN
            if (w_next[4]) begin
              index_d = w_next[3:0];
            end else begin
              state_d = C_DONE;
              index_d = '0;
            end
`else
            if (index_q == 4'd15) begin
              state_d = C_DONE;
              index_d = '0;
            end else begin
              index_d = index_q + 4'd1;
            end
`endif
          end else begin
            dwell_d = dwell_q + 4'd1;
          end
        end
      end
      C_DONE:  state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  // Outputs decode the registered state only, so reset clears them at once.
  always_comb begin
    load_ready   = 1'b0;
    demux_enable = 1'b0;
    demux_sel    = '0;
    demux_in     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_q)
      C_IDLE: load_ready = 1'b1;
      C_SCAN: begin
        demux_enable = 1'b1;
        demux_sel    = index_q;
        demux_in     = shadow_q[index_q];
        busy         = 1'b1;
      end
      C_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_demux_scan_sequencer.sv
// ============================================================================
// Module      : tb_demux_scan_sequencer
// Description : Self-checking bench for demux_scan_sequencer (two step sizes)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux_scan_sequencer;

  localparam int STEP_A = 1;
  localparam int STEP_B = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] load_data = '0;
  logic        load_valid = 1'b0;
  logic        hold = 1'b0;

  logic       rdy  [2];
  logic       din  [2];
  logic       en   [2];
  logic [3:0] sel  [2];
  logic       bsy  [2];
  logic       dn   [2];

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clock = ~clock;

  demux_scan_sequencer #(.STEP_CYCLES(STEP_A)) dut_a (
    .clock(clock), .reset(reset), .load_data(load_data), .load_valid(load_valid),
    .load_ready(rdy[0]), .hold(hold), .demux_in(din[0]), .demux_enable(en[0]),
    .demux_sel(sel[0]), .busy(bsy[0]), .done(dn[0])
  );

  demux_scan_sequencer #(.STEP_CYCLES(STEP_B)) dut_b (
    .clock(clock), .reset(reset), .load_data(load_data), .load_valid(load_valid),
    .load_ready(rdy[1]), .hold(hold), .demux_in(din[1]), .demux_enable(en[1]),
    .demux_sel(sel[1]), .busy(bsy[1]), .done(dn[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // 0 = idle, 1 = scanning, 2 = done; t counts non-held scan cycles.
  int          m_state [2];
  int          m_t     [2];
  logic [15:0] m_word  [2];

  function automatic int step_of(int k);
    return (k == 0) ? STEP_A : STEP_B;
  endfunction

  function automatic int vis_count(logic [15:0] w);
`ifdef DEMUX_SEQ_SKIP_ZERO_EN
    return $countones(w);
`else
    return 16;
`endif
  endfunction

  // n-th bit position visited by a scan of word w
  function automatic int nth_idx(logic [15:0] w, int n);
    int c = 0;
    for (int i = 0; i < 16; i++) begin
`ifdef DEMUX_SEQ_SKIP_ZERO_EN
      if (!w[i]) continue;
`endif
      if (c == n) return i;
      c++;
    end
    return 0;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) m_state[k] <= 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        case (m_state[k])
          0: if (load_valid) begin
            m_word[k]  <= load_data;
            m_t[k]     <= 0;
            m_state[k] <= (vis_count(load_data) == 0) ? 2 : 1;
          end
          1: if (!hold) begin
            m_t[k] <= m_t[k] + 1;
            if (m_t[k] + 1 == vis_count(m_word[k]) * step_of(k)) m_state[k] <= 2;
          end
          default: m_state[k] <= 0;
        endcase
      end
    end
  end

  // {load_ready, busy, done, enable, sel[3:0], in}
  localparam logic [8:0] C_IDLE_OUT = 9'b1_0_0_0_0000_0;

  function automatic logic [8:0] exp_out(int k);
    int s;
    case (m_state[k])
      0: return C_IDLE_OUT;
      1: begin
        s = nth_idx(m_word[k], m_t[k] / step_of(k));
        return {1'b0, 1'b1, 1'b0, 1'b1, 4'(s), m_word[k][s]};
      end
      default: return 9'b0_1_1_0_0000_0;
    endcase
  endfunction

  function automatic logic [8:0] act_out(int k);
    return {rdy[k], bsy[k], dn[k], en[k], sel[k], din[k]};
  endfunction

  always @(negedge clock) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++)
        chk($sformatf("model_dut%0d", k), 32'(act_out(k)), 32'(exp_out(k)));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; load_valid = 1'b0; hold = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Handshake on the next edge; returns at the negedge of scan cycle 1.
  task automatic start(input logic [15:0] w);
    load_data = w; load_valid = 1'b1;
    @(negedge clock);
    load_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] pat;
    logic [15:0] w2;
    int ne, ni, nbad, dc;

    #2 reset = 1'b1;
    #1;
    chk("async_reset_a", 32'(act_out(0)), 32'(C_IDLE_OUT));
    chk("async_reset_b", 32'(act_out(1)), 32'(C_IDLE_OUT));
    @(negedge clock);
    chk_en = 1'b1;
    chk("reset_state_a", 32'(act_out(0)), 32'(C_IDLE_OUT));
    @(negedge clock);
    reset = 1'b0;

`ifndef DEMUX_SEQ_SKIP_ZERO_EN
    // 16'hA5C3 with single-cycle steps
    do_reset();
    pat = 16'hA5C3;
    start(pat);
    for (int n = 1; n <= 16; n++) begin
      chk($sformatf("a5c3_sel%0d", n - 1), 32'(sel[0]), 32'(n - 1));
      chk($sformatf("a5c3_in%0d", n - 1), 32'(din[0]), 32'(pat[n-1]));
      chk("a5c3_nodone", 32'(dn[0]), 32'd0);
      @(negedge clock);
    end
    chk("a5c3_done17", 32'(dn[0]), 32'd1);
    chk("a5c3_en17", 32'(en[0]), 32'd0);
    @(negedge clock);
    chk("a5c3_ready18", 32'(rdy[0]), 32'd1);

    // 16'h0001 with three-cycle steps
    do_reset();
    start(16'h0001);
    ne = 0; ni = 0; nbad = 0; dc = 0;
    for (int n = 1; n <= 60; n++) begin
      if (en[1]) ne++;
      if (din[1]) ni++;
      if (din[1] && sel[1] != 4'd0) nbad++;
      if (dn[1] && dc == 0) dc = n;
      @(negedge clock);
    end
    chk("step3_scan_cycles", 32'(ne), 32'd48);
    chk("step3_in_cycles", 32'(ni), 32'd3);
    chk("step3_in_only_sel0", 32'(nbad), 32'd0);
    chk("step3_done_cycle", 32'(dc), 32'd49);

    // hold for 5 cycles at sel=7
    do_reset();
    pat = 16'($urandom);
    start(pat);
    repeat (7) @(negedge clock);
    chk("hold_pre_sel7", 32'(sel[0]), 32'd7);
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("hold_sel7", 32'(sel[0]), 32'd7);
      chk("hold_in7", 32'(din[0]), 32'(pat[7]));
    end
    hold = 1'b0;
    dc = 0;
    for (int n = 14; n <= 40 && dc == 0; n++) begin
      @(negedge clock);
      if (dn[0]) dc = n;
    end
    chk("hold_done_cycle", 32'(dc), 32'd22);

    // asynchronous reset at sel=9
    do_reset();
    start(16'hFFFF);
    repeat (9) @(negedge clock);
    chk("abort_pre_sel9", 32'(sel[0]), 32'd9);
    #1 reset = 1'b1;
    #1;
    chk("abort_async_a", 32'(act_out(0)), 32'(C_IDLE_OUT));
    chk("abort_async_b", 32'(act_out(1)), 32'(C_IDLE_OUT));
    @(negedge clock);
    reset = 1'b0;
    ne = 0;
    for (int n = 0; n < 3; n++) begin
      if (dn[0] || dn[1]) ne++;
      @(negedge clock);
    end
    chk("abort_no_done", 32'(ne), 32'd0);
    start(16'h0002);
    chk("reload_sel0", 32'(sel[0]), 32'd0);
    chk("reload_in0", 32'(din[0]), 32'd0);
    @(negedge clock);
    chk("reload_in1", 32'(din[0]), 32'd1);

    // load_valid held high: back-to-back scans
    do_reset();
    load_data = 16'h1234; load_valid = 1'b1;
    w2 = '0;
    @(negedge clock);
    for (int n = 1; n <= 20; n++) begin
      if (n <= 17) chk("b2b_notready", 32'(rdy[0]), 32'd0);
      if (n == 17) chk("b2b_done17", 32'(dn[0]), 32'd1);
      if (n == 18) chk("b2b_ready18", 32'(rdy[0]), 32'd1);
      if (n == 19) begin
        chk("b2b_en19", 32'(en[0]), 32'd1);
        chk("b2b_sel19", 32'(sel[0]), 32'd0);
        chk("b2b_in19", 32'(din[0]), 32'(w2[0]));
      end
      if (n == 20) chk("b2b_in20", 32'(din[0]), 32'(w2[1]));
      load_data = 16'($urandom);
      if (n == 18) w2 = load_data;
      @(negedge clock);
    end
    load_valid = 1'b0;
`else
    // zero-bit skipping
    do_reset();
    start(16'h8010);
    chk("skip_sel4", 32'(sel[0]), 32'd4);
    chk("skip_en", 32'(en[0]), 32'd1);
    @(negedge clock);
    chk("skip_sel15", 32'(sel[0]), 32'd15);
    @(negedge clock);
    chk("skip_done3", 32'(dn[0]), 32'd1);
    repeat (4) @(negedge clock);
    chk("skip_b_done7", 32'(dn[1]), 32'd1);
    @(negedge clock);
    start(16'h0000);
    chk("zero_done1", 32'(dn[0]), 32'd1);
    chk("zero_en1", 32'(en[0]), 32'd0);
    @(negedge clock);
    chk("zero_ready2", 32'(rdy[0]), 32'd1);
    chk("zero_en2", 32'(en[0]), 32'd0);
`endif

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      load_valid = ($urandom_range(3) != 0);
      hold       = ($urandom_range(4) == 0);
      load_data  = ($urandom_range(9) == 0) ? 16'h0000 : 16'($urandom & $urandom);
      reset      = ($urandom_range(299) == 0);
      @(negedge clock);
    end
    reset = 1'b0; load_valid = 1'b0; hold = 1'b0;
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
